// File: rtl/fb_bank_scheduler_if.sv
// ---------------------------------------------------------------------------
// fb_bank_scheduler_if
//
// Bundles the signals between the frame-buffer bank scheduler and its
// neighbours: the camera capture write port, the VGA timing block and the
// dual-port frame RAM.
//
//   cap_vsync          capture -> sched  start-of-camera-frame pulse
//   cap_we             capture -> sched  camera pixel valid
//   vga_vsync          vga     -> sched  vertical sync, active-low
//   vga_pixel_address  vga     -> sched  pixel index being scanned out
//   wr_en / wr_addr    sched   -> RAM    write strobe and {bank, index}
//   rd_addr            sched   -> RAM    read address {bank, index}
//   rd_bank            sched   -> *      bank currently displayed
//   frame_swapped      sched   -> *      one-cycle pulse on bank swap
//   drop_cnt           sched   -> *      saturating count of dropped frames
//
// The slave modport is the scheduler; master is the surrounding system.
// ---------------------------------------------------------------------------
interface fb_bank_scheduler_if #(
  parameter int AW     = 17,
  parameter int DROP_W = 8
) ();

  logic              cap_vsync;
  logic              cap_we;
  logic              vga_vsync;
  logic [AW-1:0]     vga_pixel_address;

  logic              wr_en;
  logic [AW:0]       wr_addr;
  logic [AW:0]       rd_addr;
  logic              rd_bank;
  logic              frame_swapped;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    output cap_vsync, cap_we, vga_vsync, vga_pixel_address,
    input  wr_en, wr_addr, rd_addr, rd_bank, frame_swapped, drop_cnt
  );

  modport slave (
    input  cap_vsync, cap_we, vga_vsync, vga_pixel_address,
    output wr_en, wr_addr, rd_addr, rd_bank, frame_swapped, drop_cnt
  );

endinterface

// File: rtl/fb_bank_scheduler.sv
// ---------------------------------------------------------------------------
// fb_bank_scheduler
//
// Ping-pong scheduler for the 320x240 frame buffer shared by camera capture
// and VGA scan-out. Capture writes go to the back bank, VGA reads come from
// the front bank, and the two banks are exchanged only on the falling edge
// of VGA vertical sync once a complete frame is waiting, so the display
// never shows a torn frame.
//
// Ports:
//   CLK25  pixel clock, the only clock; capture inputs are already in it
//   rst    synchronous, active-high reset
//   bus    fb_bank_scheduler_if.slave (capture, VGA and RAM signals)
//
// All outputs are registered: a pixel accepted in cycle n appears on
// wr_en/wr_addr in cycle n+1, and rd_addr follows vga_pixel_address by
// one cycle.
// ---------------------------------------------------------------------------
module fb_bank_scheduler #(
  parameter int PIXELS = 76800,
  parameter int AW     = 17,
  parameter int DROP_W = 8
) (
  input logic                CLK25,
  input logic                rst,
  fb_bank_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,       // waiting for the start of a camera frame
    WRITE,      // storing pixels of the current camera frame
    WAIT_SWAP   // back bank holds a full frame, waiting for VGA vsync
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(PIXELS - 1);

  state_t            state;
  logic              wr_bank;
  logic              rd_bank_q;
  logic              pending;    // complete frame in the back bank
  logic              vsync_d;
  logic [AW-1:0]     wr_cnt;
  logic [DROP_W-1:0] drop_q;
  logic              wr_en_q;
  logic [AW:0]       wr_addr_q;
  logic [AW:0]       rd_addr_q;
  logic              swapped_q;

  logic              vsync_fall;
  logic              do_swap;

  // vga_vsync is active-low, so its falling edge opens the sync pulse,
  // which lies well outside the active display area.
  assign vsync_fall = vsync_d & ~bus.vga_vsync;
  assign do_swap    = vsync_fall & pending;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // NOTE: every register here is assigned with <= so all right-hand sides
  // see the values from the start of the cycle; blocking assignments would
  // let a later statement observe an earlier update in the same cycle.
  always_ff @(posedge CLK25) begin
    if (rst) begin
      state     <= IDLE;
      wr_bank   <= 1'b1;
      rd_bank_q <= 1'b0;
      pending   <= 1'b0;
      vsync_d   <= 1'b1;
      wr_cnt    <= '0;
      drop_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      swapped_q <= 1'b0;
    end else begin
      // NOTE: the one-cycle strobes are driven low first and raised below
      // only in the cycles that need them, so they can never stick high.
      wr_en_q   <= 1'b0;
      swapped_q <= 1'b0;
      vsync_d   <= bus.vga_vsync;
      rd_addr_q <= {rd_bank_q, bus.vga_pixel_address};

      case (state)
        IDLE: begin
          // A pixel arriving alongside the frame start is not stored.
          if (bus.cap_vsync) begin
            state  <= WRITE;
            wr_cnt <= '0;
          end
        end

        WRITE: begin
          if (bus.cap_vsync) begin
            // New frame began before this one completed: discard it and
            // restart in the same bank. The accompanying pixel is dropped.
            wr_cnt <= '0;
            drop_q <= sat_inc(drop_q);
          end else if (bus.cap_we) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= {wr_bank, wr_cnt};
            if (wr_cnt == LAST_IDX) begin
              pending <= 1'b1;
              wr_cnt  <= '0;
              state   <= WAIT_SWAP;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end

        WAIT_SWAP: begin
          // Back bank is full and still waiting to be displayed; any frame
          // starting now is skipped entirely.
          if (bus.cap_vsync) begin
            drop_q <= sat_inc(drop_q);
          end
        end

        default: state <= IDLE;
      endcase

      // The swap overrides the writer: it goes back to IDLE so a camera
      // frame already under way is skipped and capture resumes cleanly at
      // the next cap_vsync.
      if (do_swap) begin
        rd_bank_q <= wr_bank;
        wr_bank   <= ~wr_bank;
        pending   <= 1'b0;
        swapped_q <= 1'b1;
        state     <= IDLE;
      end
    end
  end

  assign bus.wr_en         = wr_en_q;
  assign bus.wr_addr       = wr_addr_q;
  assign bus.rd_addr       = rd_addr_q;
  assign bus.rd_bank       = rd_bank_q;
  assign bus.frame_swapped = swapped_q;
  assign bus.drop_cnt      = drop_q;

endmodule

// File: tb/tb_fb_bank_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fb_bank_scheduler
//
// Two scheduler instances share CLK25:
//   dut_full  - real 76800-pixel frame: full-frame write sweep, drops while
//               waiting, drop counter saturation, swap and read address.
//   dut_small - 16-pixel frame: vector table, simultaneous-event corners,
//               reset mid-frame and a randomized run against a frame-level
//               reference model.
// Both flows run in parallel and share the comparison counters.
// ---------------------------------------------------------------------------
module tb_fb_bank_scheduler;

  localparam int AW        = 17;
  localparam int DROP_W    = 8;
  localparam int FULL_PIX  = 76800;
  localparam int SMALL_PIX = 16;
  localparam int BANK_SPAN = 1 << AW;   // address step between the banks

  logic CLK25 = 1'b0;
  logic rst_f = 1'b1;
  logic rst_s = 1'b1;

  always #5 CLK25 = ~CLK25;

  fb_bank_scheduler_if #(.AW(AW), .DROP_W(DROP_W)) bf ();
  fb_bank_scheduler_if #(.AW(AW), .DROP_W(DROP_W)) bs ();

  fb_bank_scheduler #(.PIXELS(FULL_PIX), .AW(AW), .DROP_W(DROP_W)) dut_full (
    .CLK25 (CLK25),
    .rst   (rst_f),
    .bus   (bf.slave)
  );

  fb_bank_scheduler #(.PIXELS(SMALL_PIX), .AW(AW), .DROP_W(DROP_W)) dut_small (
    .CLK25 (CLK25),
    .rst   (rst_s),
    .bus   (bs.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // NOTE: inputs are driven with blocking assignments one time unit after
  // the rising edge and outputs are sampled at that same point, so every
  // value is stable well before the next active edge.
  task automatic tick();
    @(posedge CLK25);
    #1;
  endtask

  task automatic drive_f(input logic vs, input logic we, input logic vga,
                         input logic [AW-1:0] pix);
    bf.cap_vsync = vs;
    bf.cap_we = we;
    bf.vga_vsync = vga;
    bf.vga_pixel_address = pix;
  endtask

  task automatic drive_s(input logic vs, input logic we, input logic vga,
                         input logic [AW-1:0] pix);
    bs.cap_vsync = vs;
    bs.cap_we = we;
    bs.vga_vsync = vga;
    bs.vga_pixel_address = pix;
  endtask

  // ------------------------------------------------------------------
  // Full-size frame flow
  // ------------------------------------------------------------------
  task automatic flow_full();
    int good;
    bit any_wr;

    drive_f(1'b0, 1'b0, 1'b1, '0);
    rst_f = 1'b1;
    tick();
    tick();
    check("full_rst_wr_en",   bf.wr_en, 0);
    check("full_rst_wr_addr", bf.wr_addr, 0);
    check("full_rst_rd_addr", bf.rd_addr, 0);
    check("full_rst_rd_bank", bf.rd_bank, 0);
    check("full_rst_swapped", bf.frame_swapped, 0);
    check("full_rst_drop",    bf.drop_cnt, 0);
    rst_f = 1'b0;

    // One complete frame, one pixel per cycle, into bank 1.
    drive_f(1'b1, 1'b0, 1'b1, '0);
    tick();
    good = 0;
    for (int i = 0; i < FULL_PIX; i++) begin
      drive_f(1'b0, 1'b1, 1'b1, '0);
      tick();
      if (i == 0) check("full_first_wr_addr", bf.wr_addr, 18'h20000);
      if (bf.wr_en === 1'b1 && bf.wr_addr === 18'(BANK_SPAN + i)) good++;
    end
    check("full_frame_writes", good, FULL_PIX);
    check("full_last_wr_addr", bf.wr_addr, 18'h32BFF);
    drive_f(1'b0, 1'b0, 1'b1, '0);
    tick();
    check("full_wr_en_after_frame", bf.wr_en, 0);
    check("full_no_early_swap", bf.frame_swapped, 0);
    check("full_rd_bank_before", bf.rd_bank, 0);

    // Two frames start while the full frame waits for display.
    any_wr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_f(1'b1, 1'b1, 1'b1, '0);
      tick();
      if (bf.wr_en !== 1'b0) any_wr = 1'b1;
      drive_f(1'b0, 1'b1, 1'b1, '0);
      tick();
      if (bf.wr_en !== 1'b0) any_wr = 1'b1;
    end
    check("full_drop_two", bf.drop_cnt, 2);

    // 298 more pulses: 300 in total must saturate at 255.
    for (int k = 0; k < 298; k++) begin
      drive_f(1'b1, 1'b0, 1'b1, '0);
      tick();
      if (bf.wr_en !== 1'b0) any_wr = 1'b1;
      drive_f(1'b0, 1'b0, 1'b1, '0);
      tick();
      if (bf.wr_en !== 1'b0) any_wr = 1'b1;
    end
    check("full_drop_saturate", bf.drop_cnt, 255);
    check("full_no_write_waiting", any_wr, 0);

    // VGA vsync falls: swap one cycle later.
    drive_f(1'b0, 1'b0, 1'b0, '0);
    tick();
    check("full_swap_pulse", bf.frame_swapped, 1);
    check("full_swap_rd_bank", bf.rd_bank, 1);
    drive_f(1'b0, 1'b0, 1'b1, 17'd1234);
    tick();
    check("full_swap_one_cycle", bf.frame_swapped, 0);
    check("full_rd_addr_1234", bf.rd_addr, 18'h204D2);
    check("full_drop_held", bf.drop_cnt, 255);

    // Next frame lands in bank 0.
    drive_f(1'b1, 1'b0, 1'b1, '0);
    tick();
    drive_f(1'b0, 1'b1, 1'b1, '0);
    tick();
    check("full_next_wr_en", bf.wr_en, 1);
    check("full_next_wr_addr", bf.wr_addr, 18'h00000);
    drive_f(1'b0, 1'b0, 1'b1, '0);
    tick();
    check("full_next_wr_en_drop", bf.wr_en, 0);
  endtask

  // ------------------------------------------------------------------
  // Small-frame flow
  // ------------------------------------------------------------------
  typedef struct {
    logic          vs;
    logic          we;
    logic          vga;
    logic [AW-1:0] pix;
    logic          e_wr_en;
    logic [AW:0]   e_wr_addr;
    logic [AW:0]   e_rd_addr;
    logic          e_rd_bank;
    logic          e_swapped;
    logic [7:0]    e_drop;
  } vec_t;

  task automatic flow_small();
    vec_t tv[12];
    // Frame-level reference model state.
    int  front, back, fill, drops, e_wr_addr, e_rd;
    bit  capturing, full, full_was, prev_vga, e_wr_en, e_sw, fall;
    int  vleft;
    logic vs_r, we_r, vga_r;
    logic [AW-1:0] pix_r;
    logic [46:0] exp_v, act_v;

    tv[0]  = '{1'b0, 1'b1, 1'b1, 17'd5,    1'b0, 18'h00000, 18'h00005, 1'b0, 1'b0, 8'd0};
    tv[1]  = '{1'b1, 1'b1, 1'b1, 17'd6,    1'b0, 18'h00000, 18'h00006, 1'b0, 1'b0, 8'd0};
    tv[2]  = '{1'b0, 1'b1, 1'b1, 17'd7,    1'b1, 18'h20000, 18'h00007, 1'b0, 1'b0, 8'd0};
    tv[3]  = '{1'b0, 1'b0, 1'b1, 17'd7,    1'b0, 18'h20000, 18'h00007, 1'b0, 1'b0, 8'd0};
    tv[4]  = '{1'b0, 1'b1, 1'b1, 17'd8,    1'b1, 18'h20001, 18'h00008, 1'b0, 1'b0, 8'd0};
    tv[5]  = '{1'b0, 1'b1, 1'b1, 17'd9,    1'b1, 18'h20002, 18'h00009, 1'b0, 1'b0, 8'd0};
    tv[6]  = '{1'b1, 1'b1, 1'b1, 17'd9,    1'b0, 18'h20002, 18'h00009, 1'b0, 1'b0, 8'd1};
    tv[7]  = '{1'b0, 1'b1, 1'b1, 17'd9,    1'b1, 18'h20000, 18'h00009, 1'b0, 1'b0, 8'd1};
    tv[8]  = '{1'b1, 1'b0, 1'b1, 17'd9,    1'b0, 18'h20000, 18'h00009, 1'b0, 1'b0, 8'd2};
    tv[9]  = '{1'b0, 1'b1, 1'b1, 17'd9,    1'b1, 18'h20000, 18'h00009, 1'b0, 1'b0, 8'd2};
    tv[10] = '{1'b0, 1'b0, 1'b0, 17'd9,    1'b0, 18'h20000, 18'h00009, 1'b0, 1'b0, 8'd2};
    tv[11] = '{1'b0, 1'b0, 1'b1, 17'd1234, 1'b0, 18'h20000, 18'h004D2, 1'b0, 1'b0, 8'd2};

    drive_s(1'b0, 1'b0, 1'b1, '0);
    rst_s = 1'b1;
    tick();
    tick();
    rst_s = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive_s(tv[i].vs, tv[i].we, tv[i].vga, tv[i].pix);
      tick();
      check($sformatf("vec%0d_wr_en", i),   bs.wr_en,         tv[i].e_wr_en);
      check($sformatf("vec%0d_wr_addr", i), bs.wr_addr,       tv[i].e_wr_addr);
      check($sformatf("vec%0d_rd_addr", i), bs.rd_addr,       tv[i].e_rd_addr);
      check($sformatf("vec%0d_rd_bank", i), bs.rd_bank,       tv[i].e_rd_bank);
      check($sformatf("vec%0d_swapped", i), bs.frame_swapped, tv[i].e_swapped);
      check($sformatf("vec%0d_drop", i),    bs.drop_cnt,      tv[i].e_drop);
    end

    // Last pixel (index 15) accepted in the cycle vsync_fall is evaluated:
    // no swap this time, swap at the following fall.
    for (int i = 1; i < SMALL_PIX - 1; i++) begin
      drive_s(1'b0, 1'b1, 1'b1, '0);
      tick();
    end
    drive_s(1'b0, 1'b1, 1'b0, '0);
    tick();
    check("sim_last_wr_en", bs.wr_en, 1);
    check("sim_last_wr_addr", bs.wr_addr, 18'h2000F);
    check("sim_no_swap", bs.frame_swapped, 0);
    for (int i = 0; i < 3; i++) begin
      drive_s(1'b0, 1'b0, 1'b0, '0);
      tick();
      check("sim_low_no_swap", bs.frame_swapped, 0);
    end
    check("sim_rd_bank_held", bs.rd_bank, 0);
    drive_s(1'b0, 1'b0, 1'b1, '0);
    tick();
    drive_s(1'b0, 1'b0, 1'b0, '0);
    tick();
    check("sim_late_swap", bs.frame_swapped, 1);
    check("sim_late_rd_bank", bs.rd_bank, 1);
    drive_s(1'b0, 1'b0, 1'b1, 17'd1234);
    tick();
    check("sim_swap_one_cycle", bs.frame_swapped, 0);
    check("sim_rd_addr_1234", bs.rd_addr, 18'h204D2);
    drive_s(1'b1, 1'b0, 1'b1, '0);
    tick();
    drive_s(1'b0, 1'b1, 1'b1, '0);
    tick();
    check("sim_next_wr_addr", bs.wr_addr, 18'h00000);

    // Completion pixel coinciding with cap_vsync: dropped, nothing pending.
    for (int i = 1; i < SMALL_PIX - 1; i++) begin
      drive_s(1'b0, 1'b1, 1'b1, '0);
      tick();
    end
    check("cmp_pix14_addr", bs.wr_addr, 18'h0000E);
    drive_s(1'b1, 1'b1, 1'b1, '0);
    tick();
    check("cmp_vs_no_write", bs.wr_en, 0);
    check("cmp_vs_drop", bs.drop_cnt, 3);
    drive_s(1'b0, 1'b0, 1'b0, '0);
    tick();
    check("cmp_no_swap", bs.frame_swapped, 0);
    check("cmp_rd_bank_held", bs.rd_bank, 1);
    drive_s(1'b0, 1'b1, 1'b1, '0);
    tick();
    check("cmp_restart_addr", bs.wr_addr, 18'h00000);

    // Reset mid-frame: everything back to reset values.
    drive_s(1'b0, 1'b1, 1'b1, 17'd77);
    rst_s = 1'b1;
    tick();
    check("mid_rst_wr_en",   bs.wr_en, 0);
    check("mid_rst_wr_addr", bs.wr_addr, 0);
    check("mid_rst_rd_addr", bs.rd_addr, 0);
    check("mid_rst_rd_bank", bs.rd_bank, 0);
    check("mid_rst_drop",    bs.drop_cnt, 0);
    rst_s = 1'b0;
    drive_s(1'b1, 1'b0, 1'b1, '0);
    tick();
    drive_s(1'b0, 1'b1, 1'b1, '0);
    tick();
    check("mid_rst_first_addr", bs.wr_addr, 18'h20000);

    // Randomized run against a frame-level model.
    drive_s(1'b0, 1'b0, 1'b1, '0);
    rst_s = 1'b1;
    tick();
    tick();
    rst_s = 1'b0;
    front = 0; back = 1; fill = 0; drops = 0;
    capturing = 1'b0; full = 1'b0; prev_vga = 1'b1;
    e_wr_addr = 0; e_rd = 0;
    vga_r = 1'b1;
    vleft = 20;

    for (int c = 0; c < 3000; c++) begin
      vs_r  = ($urandom_range(0, 39) == 0);
      we_r  = ($urandom_range(0, 9) < 7);
      pix_r = AW'($urandom_range(0, FULL_PIX - 1));
      if (vleft == 0) begin
        vga_r = ~vga_r;
        vleft = vga_r ? int'($urandom_range(10, 40)) : int'($urandom_range(1, 4));
      end
      vleft--;
      drive_s(vs_r, we_r, vga_r, pix_r);

      // Model: back bank is either idle, filling, or full and waiting.
      fall     = prev_vga && !vga_r;
      full_was = full;
      e_wr_en  = 1'b0;
      e_sw     = 1'b0;
      e_rd     = front * BANK_SPAN + int'(pix_r);
      if (full) begin
        if (vs_r) drops = (drops < 255) ? drops + 1 : 255;
      end else if (!capturing) begin
        if (vs_r) begin
          capturing = 1'b1;
          fill = 0;
        end
      end else if (vs_r) begin
        drops = (drops < 255) ? drops + 1 : 255;
        fill = 0;
      end else if (we_r) begin
        e_wr_en   = 1'b1;
        e_wr_addr = back * BANK_SPAN + fill;
        fill++;
        if (fill == SMALL_PIX) begin
          full = 1'b1;
          capturing = 1'b0;
          fill = 0;
        end
      end
      if (fall && full_was) begin
        front = back;
        back = 1 - back;
        full = 1'b0;
        capturing = 1'b0;
        e_sw = 1'b1;
      end
      prev_vga = vga_r;

      tick();
      exp_v = {e_wr_en, 18'(e_wr_addr), 18'(e_rd), front[0], e_sw, 8'(drops)};
      act_v = {bs.wr_en, bs.wr_addr, bs.rd_addr, bs.rd_bank, bs.frame_swapped, bs.drop_cnt};
      check($sformatf("rand_cycle%0d", c), act_v, exp_v);
    end
  endtask

  initial begin
    drive_f(1'b0, 1'b0, 1'b1, '0);
    drive_s(1'b0, 1'b0, 1'b1, '0);
    fork
      flow_full();
      flow_small();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
